// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle core: next-PC select codes and the
// PC sequencer state encoding.
package cpu_pkg;

    localparam logic [2:0] NPC_SEQ  = 3'b000;
    localparam logic [2:0] NPC_BEQ  = 3'b001;
    localparam logic [2:0] NPC_BNE  = 3'b010;
    localparam logic [2:0] NPC_J    = 3'b011;
    localparam logic [2:0] NPC_JAL  = 3'b100;
    localparam logic [2:0] NPC_JR   = 3'b101;
    localparam logic [2:0] NPC_HOLD = 3'b110;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        EXEC  = 2'b10,
        HALT  = 2'b11
    } pc_seq_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection. PC is a word address, so the sequential
// successor is PC+1 and branch offsets are in words; all sums wrap mod 2^32.
module pc_next_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [2:0]  npc_sel,
    input  logic        zero,
    input  logic [31:0] imm,
    input  logic [25:0] jump_addr,
    input  logic [31:0] bus_a,
    output logic [31:0] npc
);

    logic [31:0] pc_inc;

    assign pc_inc = pc + 32'd1;

    always_comb begin
        npc = pc_inc;
        case (npc_sel)
            NPC_BEQ:        if (zero)  npc = pc_inc + imm;
            NPC_BNE:        if (!zero) npc = pc_inc + imm;
            NPC_J, NPC_JAL: npc = {6'b0, jump_addr};
            NPC_JR:         npc = bus_a;
            NPC_HOLD:       npc = pc;
            default:        npc = pc_inc;
        endcase
    end

endmodule

// File: rtl/pc_seq.sv
// PC sequencer: owns the program counter, runs fetch/execute, commits the
// next PC on execute completion and keeps saturating performance counters.
module pc_seq
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              IFetchReq,
    output logic [31:0]       IFetchAddr,
    input  logic              IFetchAck,
    input  logic [31:0]       Instr,
    output logic [31:0]       InstrOut,
    output logic              InstrValid,
    input  logic              ExDone,
    input  logic [2:0]        nPC_sel,
    input  logic              Zero,
    input  logic [31:0]       Imm,
    input  logic [25:0]       JumpAddr,
    input  logic [31:0]       BusA,
    output logic [31:0]       PC,
    output logic              Halted,
    output logic [CNT_W-1:0]  CycleCnt,
    output logic [CNT_W-1:0]  RetireCnt,
    output pc_seq_state_t     dbg_state
);

    // Handshake: IFetchReq is held with a stable IFetchAddr until IFetchAck is
    // seen high on a rising edge while in FETCH; that edge transfers Instr.
    // ExDone is only honoured in EXEC and qualifies the branch inputs that cycle.

    pc_seq_state_t state, state_next;
    logic [31:0]   npc;
    logic          fetch_done;
    logic          commit;

    assign fetch_done = (state == FETCH) && IFetchAck;
    assign commit     = (state == EXEC) && ExDone;
    assign IFetchAddr = PC;
    assign dbg_state  = state;

    pc_next_calc u_next (
        .pc        (PC),
        .npc_sel   (nPC_sel),
        .zero      (Zero),
        .imm       (Imm),
        .jump_addr (JumpAddr),
        .bus_a     (BusA),
        .npc       (npc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = FETCH;
            FETCH:   if (IFetchAck) state_next = EXEC;
            EXEC:    if (ExDone) state_next = (nPC_sel == NPC_HOLD) ? HALT : FETCH;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    // Request and halt flags are registered from the next state so they line
    // up with the state they describe without a combinational output path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC         <= RESET_PC;
            IFetchReq  <= 1'b0;
            InstrOut   <= '0;
            InstrValid <= 1'b0;
            Halted     <= 1'b0;
            CycleCnt   <= '0;
            RetireCnt  <= '0;
        end else begin
            IFetchReq  <= (state_next == FETCH);
            Halted     <= (state_next == HALT);
            InstrValid <= fetch_done;
            if (fetch_done) InstrOut <= Instr;
            if (commit) begin
                PC <= npc;
                if (RetireCnt != '1) RetireCnt <= RetireCnt + CNT_W'(1);
            end
            if ((state == FETCH || state == EXEC) && CycleCnt != '1)
                CycleCnt <= CycleCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: walks the fetch/execute loop through sequential,
// branch, jump, stall, halt and asynchronous-reset scenarios.
module tb_pc_seq;
    import cpu_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CNT_W    = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              IFetchReq;
    logic [31:0]       IFetchAddr;
    logic              IFetchAck;
    logic [31:0]       Instr;
    logic [31:0]       InstrOut;
    logic              InstrValid;
    logic              ExDone;
    logic [2:0]        nPC_sel;
    logic              Zero;
    logic [31:0]       Imm;
    logic [25:0]       JumpAddr;
    logic [31:0]       BusA;
    logic [31:0]       PC;
    logic              Halted;
    logic [CNT_W-1:0]  CycleCnt;
    logic [CNT_W-1:0]  RetireCnt;
    pc_seq_state_t     dbg_state;

    pc_seq #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .IFetchReq  (IFetchReq),
        .IFetchAddr (IFetchAddr),
        .IFetchAck  (IFetchAck),
        .Instr      (Instr),
        .InstrOut   (InstrOut),
        .InstrValid (InstrValid),
        .ExDone     (ExDone),
        .nPC_sel    (nPC_sel),
        .Zero       (Zero),
        .Imm        (Imm),
        .JumpAddr   (JumpAddr),
        .BusA       (BusA),
        .PC         (PC),
        .Halted     (Halted),
        .CycleCnt   (CycleCnt),
        .RetireCnt  (RetireCnt),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    int          exp_cycle;
    int          exp_retire;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        IFetchAck = 1'b0;
        Instr     = 32'h0;
        ExDone    = 1'b0;
        nPC_sel   = NPC_SEQ;
        Zero      = 1'b0;
        Imm       = 32'h0;
        JumpAddr  = 26'h0;
        BusA      = 32'h0;
    endtask

    // Runs one instruction starting at a falling edge in FETCH. The fetch
    // address is popped from the expected queue; the committed PC is pushed.
    task automatic run_instr(input string tag, input logic [2:0] sel, input logic zero,
                             input logic [31:0] imm, input logic [25:0] jaddr,
                             input logic [31:0] busa, input int stall, input int exec_wait,
                             input logic [31:0] exp_next);
        logic [31:0] exp_addr;
        logic [31:0] c0;
        logic [31:0] word;
        exp_addr = RESET_PC;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s queue: expected queue empty", tag);
        end else begin
            exp_addr = exp_q.pop_front();
        end
        check($sformatf("%s req", tag), 32'(IFetchReq), 32'd1);
        check($sformatf("%s addr", tag), IFetchAddr, exp_addr);
        if (stall > 0) begin
            c0 = CycleCnt;
            for (int i = 0; i < stall; i++) begin
                ExDone   = 1'b1;
                nPC_sel  = NPC_J;
                JumpAddr = 26'h155;
                @(negedge clk);
                check($sformatf("%s stall req", tag), 32'(IFetchReq), 32'd1);
                check($sformatf("%s stall addr", tag), IFetchAddr, exp_addr);
            end
            idle_inputs();
            check($sformatf("%s stall cycles", tag), CycleCnt, c0 + stall);
            check($sformatf("%s stall retire", tag), RetireCnt, exp_retire);
        end
        word      = 32'hA500_0000 ^ exp_addr;
        Instr     = word;
        IFetchAck = 1'b1;
        @(negedge clk);
        IFetchAck = 1'b0;
        check($sformatf("%s valid", tag), 32'(InstrValid), 32'd1);
        check($sformatf("%s instr", tag), InstrOut, word);
        check($sformatf("%s state", tag), 32'(dbg_state), 32'(EXEC));
        for (int i = 0; i < exec_wait; i++) begin
            IFetchAck = 1'b1;
            nPC_sel   = NPC_HOLD;
            BusA      = 32'hDEAD_BEEF;
            @(negedge clk);
            check($sformatf("%s valid drop", tag), 32'(InstrValid), 32'd0);
            check($sformatf("%s exec pc", tag), PC, exp_addr);
        end
        IFetchAck = 1'b0;
        nPC_sel   = sel;
        Zero      = zero;
        Imm       = imm;
        JumpAddr  = jaddr;
        BusA      = busa;
        ExDone    = 1'b1;
        @(negedge clk);
        idle_inputs();
        exp_retire++;
        exp_cycle += 2 + stall + exec_wait;
        check($sformatf("%s pc", tag), PC, exp_next);
        check($sformatf("%s retire", tag), RetireCnt, exp_retire);
        check($sformatf("%s cycles", tag), CycleCnt, exp_cycle);
        exp_q.push_back(exp_next);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        check("rst pc", PC, RESET_PC);
        check("rst req", 32'(IFetchReq), 32'd0);
        check("rst instr", InstrOut, 32'd0);
        check("rst valid", 32'(InstrValid), 32'd0);
        check("rst halted", 32'(Halted), 32'd0);
        check("rst cycles", CycleCnt, 32'd0);
        check("rst retire", RetireCnt, 32'd0);
        check("rst state", 32'(dbg_state), 32'(IDLE));

        rst = 1'b0;
        exp_cycle  = 0;
        exp_retire = 0;
        exp_q.push_back(RESET_PC);
        @(negedge clk);
        check("idle to fetch", 32'(dbg_state), 32'(FETCH));

        run_instr("nop0", NPC_SEQ, 1'b0, 32'h0, 26'h0, 32'h0, 0, 0, 32'd1);
        run_instr("nop1", NPC_SEQ, 1'b0, 32'h0, 26'h0, 32'h0, 0, 0, 32'd2);
        run_instr("nop2", NPC_SEQ, 1'b0, 32'h0, 26'h0, 32'h0, 0, 0, 32'd3);
        check("three commits", RetireCnt, 32'd3);
        run_instr("nop3", NPC_SEQ, 1'b0, 32'h0, 26'h0, 32'h0, 0, 0, 32'd4);
        run_instr("beq nt", NPC_BEQ, 1'b0, 32'd10, 26'h0, 32'h0, 0, 0, 32'd5);
        run_instr("beq back", NPC_BEQ, 1'b1, 32'hFFFF_FFFE, 26'h0, 32'h0, 0, 0, 32'd4);
        run_instr("slow nop", NPC_SEQ, 1'b0, 32'h0, 26'h0, 32'h0, 0, 2, 32'd5);
        run_instr("bne nt", NPC_BNE, 1'b1, 32'd20, 26'h0, 32'h0, 0, 0, 32'd6);
        run_instr("j max", NPC_J, 1'b0, 32'h0, 26'h3FF_FFFF, 32'h0, 0, 0, 32'h03FF_FFFF);
        run_instr("jr top", NPC_JR, 1'b0, 32'h0, 26'h0, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF);
        run_instr("wrap", NPC_SEQ, 1'b0, 32'h0, 26'h0, 32'h0, 0, 0, 32'd0);
        run_instr("jal", NPC_JAL, 1'b0, 32'h0, 26'h1, 32'h0, 0, 0, 32'd1);
        run_instr("nop4", NPC_SEQ, 1'b0, 32'h0, 26'h0, 32'h0, 0, 0, 32'd2);
        run_instr("stall", NPC_SEQ, 1'b0, 32'h0, 26'h0, 32'h0, 4, 0, 32'd3);
        run_instr("nop5", NPC_SEQ, 1'b0, 32'h0, 26'h0, 32'h0, 0, 0, 32'd4);
        run_instr("nop6", NPC_SEQ, 1'b0, 32'h0, 26'h0, 32'h0, 0, 0, 32'd5);
        run_instr("nop7", NPC_SEQ, 1'b0, 32'h0, 26'h0, 32'h0, 0, 0, 32'd6);
        run_instr("nop8", NPC_SEQ, 1'b0, 32'h0, 26'h0, 32'h0, 0, 0, 32'd7);
        run_instr("halt", NPC_HOLD, 1'b0, 32'h0, 26'h0, 32'h0, 0, 0, 32'd7);

        check("halt flag", 32'(Halted), 32'd1);
        check("halt req", 32'(IFetchReq), 32'd0);
        check("halt state", 32'(dbg_state), 32'(HALT));
        for (int i = 0; i < 3; i++) begin
            IFetchAck = 1'b1;
            ExDone    = 1'b1;
            nPC_sel   = NPC_J;
            JumpAddr  = 26'h2A;
            @(negedge clk);
            check("halt pc", PC, 32'd7);
            check("halt addr", IFetchAddr, 32'd7);
            check("halt req hold", 32'(IFetchReq), 32'd0);
            check("halt cycles", CycleCnt, exp_cycle);
            check("halt retire", RetireCnt, exp_retire);
        end
        idle_inputs();

        #2 rst = 1'b1;
        #1;
        check("arst pc", PC, RESET_PC);
        check("arst halted", 32'(Halted), 32'd0);
        check("arst cycles", CycleCnt, 32'd0);
        check("arst retire", RetireCnt, 32'd0);
        check("arst state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        exp_cycle  = 0;
        exp_retire = 0;
        @(negedge clk);
        run_instr("restart", NPC_SEQ, 1'b0, 32'h0, 26'h0, 32'h0, 0, 0, 32'd1);

        IFetchAck = 1'b1;
        Instr     = 32'h1234_5678;
        #2 rst = 1'b1;
        #1;
        check("fetch rst req", 32'(IFetchReq), 32'd0);
        check("fetch rst pc", PC, RESET_PC);
        check("fetch rst instr", InstrOut, 32'd0);
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        check("post rst valid", 32'(InstrValid), 32'd0);
        check("post rst instr", InstrOut, 32'd0);
        check("post rst state", 32'(dbg_state), 32'(FETCH));
        check("post rst addr", IFetchAddr, RESET_PC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
